hazard_ctrl_mc: RTL and testbench

//  Pipeline hazard/stall/flush controller for the 5-stage (F D E M W) CPU.

---
 rtl/hazard_ctrl_mc.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// Hazard, stall and flush controller for the five-stage pipeline.
// Handles operand forwarding, load-use bubbles, flush arbitration and stall-cause counters.
module hazard_ctrl_mc #(
   parameter int NUM_SRC          = 2,
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int CNT_W            = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_stall,
   input  logic                   d_stall,
   input  logic                   div_stallE,
   input  logic                   mult_stallE,
   input  logic                   is_loadE,
   input  logic                   is_loadM,
   input  logic                   flush_pred_failedM,
   input  logic                   flush_exceptionM,
   input  logic [NUM_SRC*5-1:0]   srcD,
   input  logic [NUM_SRC*5-1:0]   srcE,
   input  logic                   reg_write_enE,
   input  logic                   reg_write_enM,
   input  logic                   reg_write_enW,
   input  logic [4:0]             reg_writeE,
   input  logic [4:0]             reg_writeM,
   input  logic [4:0]             reg_writeW,
   input  logic                   perf_clr,
   output logic                   stallF,
   output logic                   stallD,
   output logic                   stallE,
   output logic                   stallM,
   output logic                   stallW,
   output logic                   longest_stall,
   output logic                   flushF,
   output logic                   flushD,
   output logic                   flushE,
   output logic                   flushM,
   output logic                   flushW,
   output logic [NUM_SRC*2-1:0]   forwardE,
   output logic                   load_use_busy,
   output logic [CNT_W-1:0]       perf_mem_cyc,
   output logic [CNT_W-1:0]       perf_md_cyc,
   output logic [CNT_W-1:0]       perf_lu_cyc,
   output logic [CNT_W-1:0]       perf_flush_evt
);

   logic [1:0]       lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0] mem_q, mem_d, md_q, md_d, lu_q, lu_d, fl_q, fl_d;
   logic             dep, trig, stall_lu, mem_stall, md_stall;

   always_comb begin
      forwardE = '0;
      dep      = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         // M wins over W; a load in M has no data yet
         if (srcE[5*k +: 5] != 5'd0 && reg_write_enM &&
             srcE[5*k +: 5] == reg_writeM && !is_loadM)
            forwardE[2*k +: 2] = 2'b01;
         else if (srcE[5*k +: 5] != 5'd0 && reg_write_enW &&
                  srcE[5*k +: 5] == reg_writeW)
            forwardE[2*k +: 2] = 2'b10;
         if (srcD[5*k +: 5] != 5'd0 && reg_write_enE &&
             srcD[5*k +: 5] == reg_writeE)
            dep = 1'b1;
      end
   end

   assign mem_stall     = i_stall | d_stall;
   assign md_stall      = div_stallE | mult_stallE;
   assign longest_stall = mem_stall | md_stall;
   assign trig          = (lu_cnt_q == 2'd0) & is_loadE & dep &
                          ~flush_exceptionM & ~flush_pred_failedM;
   assign stall_lu      = trig | (lu_cnt_q != 2'd0);
   assign load_use_busy = stall_lu;

   assign stallF = longest_stall | stall_lu;
   assign stallD = longest_stall | stall_lu;
   assign stallE = longest_stall;
   assign stallM = longest_stall;
   assign stallW = longest_stall;
   assign flushF = 1'b0;
   assign flushD = flush_exceptionM;
   assign flushM = flush_exceptionM;
   assign flushW = flush_exceptionM;
   assign flushE = flush_exceptionM |
                   ((flush_pred_failedM | stall_lu) & ~longest_stall);

   // Frozen cycles keep the remaining bubble count untouched
   always_comb begin
      lu_cnt_d = 2'd0;
      if (flush_exceptionM)
         lu_cnt_d = 2'd0;
      else if (flush_pred_failedM && !longest_stall)
         lu_cnt_d = 2'd0;
      else if (longest_stall)
         lu_cnt_d = lu_cnt_q;
      else if (trig)
         lu_cnt_d = 2'(LOAD_USE_BUBBLES - 1);
      else if (lu_cnt_q != 2'd0)
         lu_cnt_d = lu_cnt_q - 2'd1;
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] q,
                                                input logic inc);
      return (inc && q != '1) ? q + CNT_W'(1) : q;
   endfunction

   always_comb begin
      mem_d = perf_clr ? '0 : sat_inc(mem_q, mem_stall);
      md_d  = perf_clr ? '0 : sat_inc(md_q, md_stall & ~mem_stall);
      lu_d  = perf_clr ? '0 : sat_inc(lu_q, stall_lu & ~longest_stall);
      fl_d  = perf_clr ? '0 : sat_inc(fl_q, flush_exceptionM |
                                      (flush_pred_failedM & ~longest_stall));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lu_cnt_q <= 2'd0;
         mem_q    <= '0;
         md_q     <= '0;
         lu_q     <= '0;
         fl_q     <= '0;
      end else begin
         lu_cnt_q <= lu_cnt_d;
         mem_q    <= mem_d;
         md_q     <= md_d;
         lu_q     <= lu_d;
         fl_q     <= fl_d;
      end
   end

   assign perf_mem_cyc   = mem_q;
   assign perf_md_cyc    = md_q;
   assign perf_lu_cyc    = lu_q;
   assign perf_flush_evt = fl_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc across four parameter sets.
// Stimulus queues expected values; a negedge monitor pops and compares.
module tb_hazard_ctrl_mc;

   bit   clk = 1'b0;
   logic rst = 1'b1;
   logic i_stall, d_stall, div_stallE, mult_stallE;
   logic is_loadE, is_loadM, flush_pred_failedM, flush_exceptionM;
   logic [9:0] srcD, srcE;
   logic reg_write_enE, reg_write_enM, reg_write_enW;
   logic [4:0] reg_writeE, reg_writeM, reg_writeW;
   logic perf_clr;

   logic [4:0]  sta, stb, stc, std, fla, flb, flc, fld;
   logic        lga, lgb, lgc, lgd, bza, bzb, bzc, bzd;
   logic [3:0]  fwa, fwb, fwc, fwd;
   logic [31:0] pma, pda, pla, pfa, pmb, pdb, plb, pfb, pmc, pdc, plc, pfc;
   logic [3:0]  pmd, pdd, pld, pfd;

   int pcyc = 0;
   int tests = 0;
   int fails = 0;

   localparam logic [31:0] SF = 32'h800, SD = 32'h400, SE = 32'h200;
   localparam logic [31:0] SM = 32'h100, SW = 32'h080, LG = 32'h040;
   localparam logic [31:0] FD = 32'h010, FE = 32'h008;
   localparam logic [31:0] FM = 32'h004, FW = 32'h002, BZ = 32'h001;
   localparam logic [31:0] ALLST = SF | SD | SE | SM | SW | LG;
   localparam logic [31:0] LUB = SF | SD | FE | BZ;

   typedef struct {
      int          cyc;
      int          inst;
      int          sig;
      logic [31:0] exp;
      string       nm;
   } item_t;
   item_t sb[$];

   hazard_ctrl_mc #(.NUM_SRC(2), .LOAD_USE_BUBBLES(1), .CNT_W(32)) u1 (
      .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
      .div_stallE(div_stallE), .mult_stallE(mult_stallE),
      .is_loadE(is_loadE), .is_loadM(is_loadM),
      .flush_pred_failedM(flush_pred_failedM),
      .flush_exceptionM(flush_exceptionM), .srcD(srcD), .srcE(srcE),
      .reg_write_enE(reg_write_enE), .reg_write_enM(reg_write_enM),
      .reg_write_enW(reg_write_enW), .reg_writeE(reg_writeE),
      .reg_writeM(reg_writeM), .reg_writeW(reg_writeW), .perf_clr(perf_clr),
      .stallF(sta[4]), .stallD(sta[3]), .stallE(sta[2]), .stallM(sta[1]),
      .stallW(sta[0]), .longest_stall(lga),
      .flushF(fla[4]), .flushD(fla[3]), .flushE(fla[2]), .flushM(fla[1]),
      .flushW(fla[0]), .forwardE(fwa), .load_use_busy(bza),
      .perf_mem_cyc(pma), .perf_md_cyc(pda), .perf_lu_cyc(pla),
      .perf_flush_evt(pfa));

   hazard_ctrl_mc #(.NUM_SRC(2), .LOAD_USE_BUBBLES(3), .CNT_W(32)) u3 (
      .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
      .div_stallE(div_stallE), .mult_stallE(mult_stallE),
      .is_loadE(is_loadE), .is_loadM(is_loadM),
      .flush_pred_failedM(flush_pred_failedM),
      .flush_exceptionM(flush_exceptionM), .srcD(srcD), .srcE(srcE),
      .reg_write_enE(reg_write_enE), .reg_write_enM(reg_write_enM),
      .reg_write_enW(reg_write_enW), .reg_writeE(reg_writeE),
      .reg_writeM(reg_writeM), .reg_writeW(reg_writeW), .perf_clr(perf_clr),
      .stallF(stb[4]), .stallD(stb[3]), .stallE(stb[2]), .stallM(stb[1]),
      .stallW(stb[0]), .longest_stall(lgb),
      .flushF(flb[4]), .flushD(flb[3]), .flushE(flb[2]), .flushM(flb[1]),
      .flushW(flb[0]), .forwardE(fwb), .load_use_busy(bzb),
      .perf_mem_cyc(pmb), .perf_md_cyc(pdb), .perf_lu_cyc(plb),
      .perf_flush_evt(pfb));

   hazard_ctrl_mc #(.NUM_SRC(2), .LOAD_USE_BUBBLES(4), .CNT_W(32)) u4 (
      .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
      .div_stallE(div_stallE), .mult_stallE(mult_stallE),
      .is_loadE(is_loadE), .is_loadM(is_loadM),
      .flush_pred_failedM(flush_pred_failedM),
      .flush_exceptionM(flush_exceptionM), .srcD(srcD), .srcE(srcE),
      .reg_write_enE(reg_write_enE), .reg_write_enM(reg_write_enM),
      .reg_write_enW(reg_write_enW), .reg_writeE(reg_writeE),
      .reg_writeM(reg_writeM), .reg_writeW(reg_writeW), .perf_clr(perf_clr),
      .stallF(stc[4]), .stallD(stc[3]), .stallE(stc[2]), .stallM(stc[1]),
      .stallW(stc[0]), .longest_stall(lgc),
      .flushF(flc[4]), .flushD(flc[3]), .flushE(flc[2]), .flushM(flc[1]),
      .flushW(flc[0]), .forwardE(fwc), .load_use_busy(bzc),
      .perf_mem_cyc(pmc), .perf_md_cyc(pdc), .perf_lu_cyc(plc),
      .perf_flush_evt(pfc));

   hazard_ctrl_mc #(.NUM_SRC(2), .LOAD_USE_BUBBLES(1), .CNT_W(4)) uc (
      .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
      .div_stallE(div_stallE), .mult_stallE(mult_stallE),
      .is_loadE(is_loadE), .is_loadM(is_loadM),
      .flush_pred_failedM(flush_pred_failedM),
      .flush_exceptionM(flush_exceptionM), .srcD(srcD), .srcE(srcE),
      .reg_write_enE(reg_write_enE), .reg_write_enM(reg_write_enM),
      .reg_write_enW(reg_write_enW), .reg_writeE(reg_writeE),
      .reg_writeM(reg_writeM), .reg_writeW(reg_writeW), .perf_clr(perf_clr),
      .stallF(std[4]), .stallD(std[3]), .stallE(std[2]), .stallM(std[1]),
      .stallW(std[0]), .longest_stall(lgd),
      .flushF(fld[4]), .flushD(fld[3]), .flushE(fld[2]), .flushM(fld[1]),
      .flushW(fld[0]), .forwardE(fwd), .load_use_busy(bzd),
      .perf_mem_cyc(pmd), .perf_md_cyc(pdd), .perf_lu_cyc(pld),
      .perf_flush_evt(pfd));

   always #5 clk = ~clk;
   always @(posedge clk) pcyc <= pcyc + 1;

   function automatic logic [31:0] act(input int inst, input int sig);
      logic [4:0]  st, fl;
      logic        lg, bz;
      logic [3:0]  fw;
      logic [31:0] p[4];
      case (inst)
         0: begin st = sta; fl = fla; lg = lga; bz = bza; fw = fwa;
                  p = '{pma, pda, pla, pfa}; end
         1: begin st = stb; fl = flb; lg = lgb; bz = bzb; fw = fwb;
                  p = '{pmb, pdb, plb, pfb}; end
         2: begin st = stc; fl = flc; lg = lgc; bz = bzc; fw = fwc;
                  p = '{pmc, pdc, plc, pfc}; end
         default: begin st = std; fl = fld; lg = lgd; bz = bzd; fw = fwd;
                  p = '{32'(pmd), 32'(pdd), 32'(pld), 32'(pfd)}; end
      endcase
      case (sig)
         0:       return {20'd0, st, lg, fl, bz};
         1:       return {28'd0, fw};
         default: return p[sig-2];
      endcase
   endfunction

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= pcyc) begin
         item_t it;
         logic [31:0] a;
         it = sb.pop_front();
         tests++;
         if (it.cyc < pcyc) begin
            fails++;
            $display("FAIL %s: check missed its cycle %0d", it.nm, it.cyc);
         end else begin
            a = act(it.inst, it.sig);
            if (a !== it.exp) begin
               fails++;
               $display("FAIL %s: got %0h expected %0h", it.nm, a, it.exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input int inst, input int sig, input logic [31:0] e,
                      input string nm);
      item_t it;
      it.cyc = pcyc; it.inst = inst; it.sig = sig; it.exp = e; it.nm = nm;
      sb.push_back(it);
   endtask

   task automatic clr_in();
      i_stall = 0; d_stall = 0; div_stallE = 0; mult_stallE = 0;
      is_loadE = 0; is_loadM = 0; flush_pred_failedM = 0;
      flush_exceptionM = 0; srcD = '0; srcE = '0;
      reg_write_enE = 0; reg_write_enM = 0; reg_write_enW = 0;
      reg_writeE = '0; reg_writeM = '0; reg_writeW = '0; perf_clr = 0;
   endtask

   task automatic reset_pulse();
      step(); clr_in(); rst = 1'b0;
      step(); rst = 1'b1;
   endtask

   task automatic load_dep();
      is_loadE = 1; reg_write_enE = 1; reg_writeE = 5'd3;
      srcD = {5'd3, 5'd0};
   endtask

   task automatic clr_load();
      is_loadE = 0; reg_write_enE = 0; reg_writeE = 5'd0;
   endtask

   initial begin
      clr_in();
      step(); rst = 1'b0;
      chk(0, 0, 0, "rst_flags"); chk(0, 1, 0, "rst_fwd");
      chk(0, 4, 0, "rst_lu");    chk(3, 2, 0, "rst_mem_c4");
      step(); rst = 1'b1;

      // forwarding
      step(); srcE = {5'd0, 5'd5};
      reg_write_enM = 1; reg_writeM = 5'd5; reg_write_enW = 1; reg_writeW = 5'd5;
      chk(0, 1, 32'h1, "fwd_m_beats_w");
      step(); is_loadM = 1; chk(0, 1, 32'h2, "fwd_loadm_to_w");
      step(); srcE = '0;    chk(0, 1, 32'h0, "fwd_r0");
      step(); is_loadM = 0; srcE = {5'd7, 5'd5}; reg_writeW = 5'd7;
      chk(0, 1, 32'h9, "fwd_two_src");

      // load-use, one bubble
      reset_pulse();
      step(); is_loadE = 1; reg_write_enE = 1; reg_writeE = 5'd3;
      srcD = {5'd4, 5'd2}; chk(0, 0, 0, "lu_nodep");
      step(); reg_writeE = 5'd0; srcD = '0; chk(0, 0, 0, "lu_r0");
      step(); load_dep(); chk(0, 0, LUB, "b1_bubble");
      step(); clr_load(); chk(0, 0, 0, "b1_done"); chk(0, 4, 1, "b1_perf_lu");

      // mispredict and multicycle units
      step(); srcD = '0; flush_pred_failedM = 1; chk(0, 0, FE, "pred_flush");
      step(); i_stall = 1; chk(0, 0, ALLST, "pred_frozen");
      step(); i_stall = 0; flush_pred_failedM = 0; mult_stallE = 1;
      chk(0, 0, ALLST, "mult_stall"); chk(0, 5, 1, "pred_evt");
      chk(0, 2, 1, "istall_mem");
      step(); mult_stallE = 0; chk(0, 0, 0, "idle");
      chk(0, 3, 1, "mult_md");   chk(0, 4, 1, "lu_unchanged");

      // three bubbles with d_stall freeze
      reset_pulse();
      step(); load_dep(); chk(1, 0, LUB, "b3_bub1");
      step(); clr_load(); d_stall = 1; chk(1, 0, ALLST | BZ, "b3_frz1");
      step(); chk(1, 0, ALLST | BZ, "b3_frz2");
      step(); d_stall = 0; chk(1, 0, LUB, "b3_bub2");
      step(); chk(1, 0, LUB, "b3_bub3");
      step(); chk(1, 0, 0, "b3_done");
      chk(1, 2, 2, "b3_mem"); chk(1, 4, 3, "b3_lu");

      // exception during second bubble
      reset_pulse();
      step(); load_dep(); chk(1, 0, LUB, "exc_bub1");
      step(); clr_load(); flush_exceptionM = 1;
      chk(1, 0, SF | SD | FD | FE | FM | FW | BZ, "exc_flags");
      step(); flush_exceptionM = 0; chk(1, 0, 0, "exc_after");
      chk(1, 5, 1, "exc_evt");

      // async reset while four-bubble count is live
      reset_pulse();
      step(); load_dep(); chk(2, 0, LUB, "b4_bub1");
      step(); clr_load(); chk(2, 0, LUB, "b4_bub2"); chk(2, 4, 1, "b4_lu1");
      step(); rst = 1'b0; chk(2, 0, 0, "rstmid_flags");
      chk(2, 4, 0, "rstmid_lu");
      step(); rst = 1'b1; chk(2, 0, 0, "rstmid_after");

      // 4-bit counter saturation and clear
      reset_pulse();
      step(); d_stall = 1;
      repeat (19) step();
      step(); d_stall = 0; chk(3, 2, 15, "sat_mem");
      step(); perf_clr = 1; chk(3, 2, 15, "sat_hold");
      step(); perf_clr = 0; chk(3, 2, 0, "sat_clr");

      repeat (3) step();
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard: %0d checks never compared", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
